// File: rtl/hdlc_tx_frame_ctrl_if.sv
// Bus between the Tx buffer/register block (master) and the HDLC transmit
// frame controller (slave). The serial line and status come back to the master.
interface hdlc_tx_frame_ctrl_if;
  logic       TxEN;
  logic       Tx_Enable;
  logic       Tx_AbortFrame;
  logic [7:0] Tx_FrameSize;
  logic [7:0] Tx_DataOutBuff;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  modport master (
    output TxEN, Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_DataOutBuff,
    input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
  );

  modport slave (
    input  TxEN, Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_DataOutBuff,
    output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
  );
endinterface

// File: rtl/hdlc_tx_frame_ctrl.sv
// HDLC transmit frame sequencer: reads queued bytes from the Tx buffer and
// serialises flag / data / FCS / flag one bit per clock, with in-line zero
// insertion and abort generation. The line idles at '1'.
//
// Timing model: every register edge decides the bit that is on Tx for the
// following cycle. state_q and the counters therefore describe the *next*
// bit to emit, and tx_q holds the bit currently on the line.
module hdlc_tx_frame_ctrl #(
  parameter int MAX_BYTES = 126
) (
  input  logic                 Clk,
  input  logic                 Rst,
  hdlc_tx_frame_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SFLAG, DATA, FCS, EFLAG, ABORT} state_t;

  // Flag 0,1,1,1,1,1,1,0 sent LSB first.
  localparam logic [7:0] FLAG = 8'h7E;

  state_t      state_q;
  logic [4:0]  cnt_q;      // bit index within flag/byte/FCS/abort pattern
  logic [2:0]  ones_q;     // run of consecutive '1's for zero insertion
  logic [7:0]  size_q;     // latched frame size
  logic [7:0]  byte_q;     // index of byte being sent
  logic [7:0]  shift_q;    // byte being sent
  logic [7:0]  hold_q;     // prefetched next byte
  logic        rd_dly_q;   // buffer data is valid this cycle
  logic [15:0] crc_q;
  logic        line_idle_q;
  logic        tx_q, valid_q, rd_q, aborted_q, done_q;

  logic [7:0]  cur_byte;
  logic        data_bit, fcs_bit, start_ok, abort_req;
  logic [15:0] crc_upd;

  // Next data bit, CRC step and start/abort qualification.
  always_comb begin
    // Bit 0 of a byte comes straight from the buffer if it is arriving now,
    // otherwise from the prefetch register.
    cur_byte = shift_q;
    if (cnt_q == 5'd0) cur_byte = rd_dly_q ? bus.Tx_DataOutBuff : hold_q;
    data_bit  = cur_byte[cnt_q[2:0]];
    fcs_bit   = ~crc_q[cnt_q[3:0]];
    crc_upd   = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ data_bit) ? 16'h8408 : 16'h0000);
    start_ok  = bus.Tx_Enable && bus.TxEN && line_idle_q &&
                (bus.Tx_FrameSize != 8'd0) && (int'(bus.Tx_FrameSize) <= MAX_BYTES);
    abort_req = bus.Tx_AbortFrame || !bus.TxEN;
  end

  // Frame sequencer with registered line/status outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ones_q      <= '0;
      size_q      <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      rd_dly_q    <= 1'b0;
      crc_q       <= '0;
      line_idle_q <= 1'b1;
      tx_q        <= 1'b1;
      valid_q     <= 1'b0;
      rd_q        <= 1'b0;
      aborted_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_q        <= 1'b0;
      done_q      <= 1'b0;
      line_idle_q <= 1'b0;
      rd_dly_q    <= rd_q;
      if (rd_dly_q) hold_q <= bus.Tx_DataOutBuff;

      case (state_q)
        IDLE: begin
          tx_q        <= 1'b1;
          valid_q     <= 1'b0;
          line_idle_q <= 1'b1;
          // Only start once an idle bit has actually been on the line.
          if (start_ok) begin
            size_q      <= bus.Tx_FrameSize;
            aborted_q   <= 1'b0;
            rd_q        <= 1'b1;
            tx_q        <= FLAG[0];
            valid_q     <= 1'b1;
            line_idle_q <= 1'b0;
            cnt_q       <= 5'd1;
            byte_q      <= '0;
            ones_q      <= '0;
            crc_q       <= 16'hFFFF;
            state_q     <= SFLAG;
          end
        end

        SFLAG, DATA, FCS: begin
          valid_q <= 1'b1;
          if (abort_req) begin
            // Abort pattern bit 0 replaces the next frame bit.
            tx_q      <= 1'b0;
            valid_q   <= 1'b0;
            aborted_q <= 1'b1;
            cnt_q     <= 5'd1;
            state_q   <= ABORT;
          end else if (state_q == SFLAG) begin
            tx_q  <= FLAG[cnt_q[2:0]];
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q   <= '0;
              ones_q  <= '0;
              state_q <= DATA;
            end
          end else if (ones_q == 3'd5) begin
            // Stuffed zero: index stalls, CRC untouched.
            tx_q   <= 1'b0;
            ones_q <= '0;
            if (state_q == FCS && cnt_q == 5'd16) begin
              cnt_q   <= '0;
              state_q <= EFLAG;
            end
          end else if (state_q == DATA) begin
            tx_q   <= data_bit;
            crc_q  <= crc_upd;
            ones_q <= data_bit ? ones_q + 3'd1 : 3'd0;
            if (cnt_q == 5'd0) shift_q <= cur_byte;
            if (cnt_q == 5'd6 && byte_q != size_q - 8'd1) rd_q <= 1'b1;
            if (cnt_q == 5'd7) begin
              cnt_q  <= '0;
              byte_q <= byte_q + 8'd1;
              if (byte_q == size_q - 8'd1) state_q <= FCS;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end else begin
            tx_q   <= fcs_bit;
            ones_q <= fcs_bit ? ones_q + 3'd1 : 3'd0;
            if (cnt_q == 5'd15) begin
              // A trailing run of five still needs its stuffed zero.
              if (fcs_bit && ones_q == 3'd4) begin
                cnt_q <= 5'd16;
              end else begin
                cnt_q   <= '0;
                state_q <= EFLAG;
              end
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        EFLAG: begin
          tx_q    <= FLAG[cnt_q[2:0]];
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        ABORT: begin
          tx_q    <= 1'b1;
          valid_q <= 1'b0;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd7) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Tx              = tx_q;
  assign bus.Tx_ValidFrame   = valid_q;
  assign bus.Tx_RdBuff       = rd_q;
  assign bus.Tx_AbortedTrans = aborted_q;
  assign bus.Tx_Done         = done_q;

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Bench for hdlc_tx_frame_ctrl: builds each expected frame bit stream into a
// scoreboard queue when a start is driven and pops it bit by bit off the line.
module tb_hdlc_tx_frame_ctrl;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hdlc_tx_frame_ctrl_if bus();

  hdlc_tx_frame_ctrl #(.MAX_BYTES(126)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem [0:1023];
  int         rd_cnt = 0;
  bit         exp_q[$];
  logic [7:0] pay[$];

  // Tx buffer model: data valid the cycle after the read strobe.
  always @(posedge Clk) begin
    if (bus.Tx_RdBuff) begin
      bus.Tx_DataOutBuff <= mem[rd_cnt % 1024];
      rd_cnt             <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input bit b);
    logic fb;
    fb = c[0] ^ b;
    c  = c >> 1;
    if (fb) c = c ^ 16'h8408;
    return c;
  endfunction

  // Expected line bits: flag, stuffed(data + ~CRC), flag.
  task automatic build_frame(input int n);
    bit         raw[$];
    logic [15:0] c;
    logic [7:0] f;
    logic [7:0] b;
    int         ones;
    c    = 16'hFFFF;
    f    = 8'h7E;
    ones = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
    for (int k = 0; k < n; k++) begin
      b = pay[k];
      for (int i = 0; i < 8; i++) begin
        raw.push_back(b[i]);
        c = crc_bit(c, b[i]);
      end
    end
    c = ~c;
    for (int i = 0; i < 16; i++) raw.push_back(c[i]);
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
  endtask

  // mode: 0 normal, 1 Tx_AbortFrame at pos, 2 Rst at pos, 3 TxEN low at pos,
  //       4 normal with Tx_AbortFrame raised together with the start strobe.
  task automatic run_frame(input int n, input int mode, input int at, input int exp_rd);
    int base;
    int pos;
    bit e;
    base = rd_cnt;
    for (int i = 0; i < n; i++) mem[(base + i) % 1024] = pay[i];
    build_frame(n);
    @(negedge Clk);
    bus.Tx_FrameSize  = 8'(n);
    bus.Tx_Enable     = 1'b1;
    bus.Tx_AbortFrame = (mode == 4);
    pos = 0;
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      if (pos == 0) begin
        bus.Tx_Enable     = 1'b0;
        bus.Tx_AbortFrame = 1'b0;
        chk("aborted_clr", bus.Tx_AbortedTrans, 0);
      end
      e = exp_q.pop_front();
      chk($sformatf("tx[%0d]", pos), bus.Tx, e);
      chk($sformatf("valid[%0d]", pos), bus.Tx_ValidFrame, 1);
      chk($sformatf("done[%0d]", pos), bus.Tx_Done, exp_q.size() == 0);
      if (pos == at && mode == 2) begin
        Rst = 1'b1;
        #1;
        chk("rst_tx", bus.Tx, 1);
        chk("rst_valid", bus.Tx_ValidFrame, 0);
        chk("rst_rd", bus.Tx_RdBuff, 0);
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
      if (pos == at && (mode == 1 || mode == 3)) begin
        if (mode == 1) bus.Tx_AbortFrame = 1'b1;
        else           bus.TxEN = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
          @(negedge Clk);
          bus.Tx_AbortFrame = 1'b0;
          bus.TxEN          = 1'b1;
          chk($sformatf("abort_tx[%0d]", i), bus.Tx, (i != 0));
          chk("abort_valid", bus.Tx_ValidFrame, 0);
          chk("abort_done", bus.Tx_Done, 0);
          chk("abort_flag", bus.Tx_AbortedTrans, 1);
        end
        break;
      end
      pos++;
    end
    @(negedge Clk);
    chk("idle_tx", bus.Tx, 1);
    chk("idle_valid", bus.Tx_ValidFrame, 0);
    chk("idle_done", bus.Tx_Done, 0);
    chk("rd_count", rd_cnt - base, exp_rd);
  endtask

  task automatic reject(input logic [7:0] sz, input logic en, input string tag);
    int base;
    base = rd_cnt;
    @(negedge Clk);
    bus.TxEN         = en;
    bus.Tx_FrameSize = sz;
    bus.Tx_Enable    = 1'b1;
    @(negedge Clk);
    bus.Tx_Enable = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk({tag, "_tx"}, bus.Tx, 1);
      chk({tag, "_valid"}, bus.Tx_ValidFrame, 0);
    end
    chk({tag, "_rd"}, rd_cnt - base, 0);
    bus.TxEN = 1'b1;
  endtask

  initial begin
    int n;
    Rst               = 1'b1;
    bus.TxEN          = 1'b1;
    bus.Tx_Enable     = 1'b0;
    bus.Tx_AbortFrame = 1'b0;
    bus.Tx_FrameSize  = 8'd0;
    repeat (2) @(negedge Clk);
    chk("rst_tx", bus.Tx, 1);
    chk("rst_valid", bus.Tx_ValidFrame, 0);
    chk("rst_rd", bus.Tx_RdBuff, 0);
    chk("rst_aborted", bus.Tx_AbortedTrans, 0);
    chk("rst_done", bus.Tx_Done, 0);
    Rst = 1'b0;
    @(negedge Clk);

    pay = '{8'h00};
    run_frame(1, 0, -1, 1);

    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    run_frame(9, 0, -1, 9);

    pay = '{8'hFF};
    run_frame(1, 0, -1, 1);

    pay = '{8'hFF, 8'hFF, 8'h7E};
    run_frame(3, 0, -1, 3);

    // Abort in data byte 2, bit 3 (no stuffing in these bytes).
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(4, 1, 27, 3);

    // Next start clears the sticky abort flag; abort with start is ignored.
    pay = '{8'hA5, 8'h3C};
    run_frame(2, 4, -1, 2);

    reject(8'd0,   1'b1, "sz0");
    reject(8'd127, 1'b1, "sz127");
    reject(8'd1,   1'b0, "txen0");

    // Reset in the middle of FCS, then a clean 2-byte frame.
    pay = '{8'hA5, 8'h3C};
    run_frame(2, 2, 30, 0);
    chk("post_rst_aborted", bus.Tx_AbortedTrans, 0);
    run_frame(2, 0, -1, 2);

    // TxEN dropped during data byte 0.
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(4, 3, 13, 1);

    // Random payloads, including the largest accepted size.
    for (int r = 0; r < 3; r++) begin
      n = (r == 2) ? 126 : $urandom_range(2, 20);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
      run_frame(n, 0, -1, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
